// File: rtl/lcd_scanner_pkg.sv
// lcd_scanner_pkg
//   Shared types and constants for the LCD frame scanner.
//   - state_t     : scanner FSM states
//   - SOF_BIT     : position of the start-of-frame flag in a queue word
//   - R/G/B slices: RGB565 field positions inside a 16-bit pixel
//   - in_range()  : half-open interval test on counter values
package lcd_scanner_pkg;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    STREAM    = 1'b1
  } state_t;

  localparam int CNT_W   = 16;
  localparam int WORD_W  = 17;
  localparam int PIX_W   = 16;
  localparam int SOF_BIT = 16;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // lo <= x < hi, done as one unsigned subtract: when x < lo the difference
  // wraps to a large value and fails the compare. Needs hi - lo < 2**CNT_W.
  function automatic logic in_range(input logic [CNT_W-1:0] x,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (x - lo) < (hi - lo);
  endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
//   Free-running horizontal/vertical raster counters for the LCD panel.
//   Ports:
//     clk, reset_n        : pixel clock, synchronous active-low reset
//     h_cnt, v_cnt        : current raster position
//     active              : position lies in the visible area
//     hsync_raw/vsync_raw : unregistered active-low syncs for this position
//     frame_end           : last position of the frame (H_TOTAL-1, V_TOTAL-1)
module lcd_timing_gen
  import lcd_scanner_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BACK   = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 29
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_cnt_reg;
  logic [CNT_W-1:0] v_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == H_LAST) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 1'b1;
    end
  end

  assign h_cnt     = h_cnt_reg;
  assign v_cnt     = v_cnt_reg;
  assign active    = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign hsync_raw = !in_range(h_cnt_reg, H_SYNC_BEG, H_SYNC_END);
  assign vsync_raw = !in_range(v_cnt_reg, V_SYNC_BEG, V_SYNC_END);
  assign frame_end = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);

endmodule

// File: rtl/lcd_frame_scanner.sv
// lcd_frame_scanner
//   Drains a first-word-fall-through pixel queue and drives an RGB565 panel.
//   The stored image sits in a fixed window; border colour fills the rest.
//   Ports:
//     clk, reset_n              : pixel clock, synchronous active-low reset
//     queue_data/queue_empty    : queue head ([16]=SOF, [15:0]=RGB565)
//     queue_rd_en               : pop head this cycle (combinational)
//     lcd_de/hsync/vsync/r/g/b  : registered panel outputs
//     err_clear                 : clears the sticky error flags
//     underflow_err, align_err  : sticky error flags
//     frame_count               : frames streamed without error (wrapping)
module lcd_frame_scanner
  import lcd_scanner_pkg::*;
#(
  parameter int          H_ACTIVE        = 800,
  parameter int          H_FRONT         = 40,
  parameter int          H_SYNC          = 48,
  parameter int          H_BACK          = 40,
  parameter int          V_ACTIVE        = 480,
  parameter int          V_FRONT         = 13,
  parameter int          V_SYNC          = 3,
  parameter int          V_BACK          = 29,
  parameter int          IMAGE_WIDTH     = 640,
  parameter int          IMAGE_HEIGHT    = 480,
  parameter int          X_OFFSET        = 80,
  parameter int          Y_OFFSET        = 0,
  parameter logic [15:0] BORDER_COLOR    = 16'h0000,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] queue_data,
  input  logic              queue_empty,
  output logic              queue_rd_en,
  output logic              lcd_de,
  output logic              lcd_hsync,
  output logic              lcd_vsync,
  output logic [4:0]        lcd_r,
  output logic [5:0]        lcd_g,
  output logic [4:0]        lcd_b,
  input  logic              err_clear,
  output logic              underflow_err,
  output logic              align_err,
  output logic [15:0]       frame_count
);

  localparam logic [CNT_W-1:0] X_BEG  = CNT_W'(X_OFFSET);
  localparam logic [CNT_W-1:0] X_END  = CNT_W'(X_OFFSET + IMAGE_WIDTH);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_OFFSET + IMAGE_WIDTH - 1);
  localparam logic [CNT_W-1:0] Y_BEG  = CNT_W'(Y_OFFSET);
  localparam logic [CNT_W-1:0] Y_END  = CNT_W'(Y_OFFSET + IMAGE_HEIGHT);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y_OFFSET + IMAGE_HEIGHT - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;
  logic             hsync_raw;
  logic             vsync_raw;
  logic             frame_end;

  lcd_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clk       (clk),
    .reset_n   (reset_n),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .frame_end (frame_end)
  );

  logic             in_window;
  logic             first_px;
  logic             last_px;
  logic             head_sof;
  logic [PIX_W-1:0] head_pix;

  assign in_window = in_range(h_cnt, X_BEG, X_END) && in_range(v_cnt, Y_BEG, Y_END);
  assign first_px  = (h_cnt == X_BEG)  && (v_cnt == Y_BEG);
  assign last_px   = (h_cnt == X_LAST) && (v_cnt == Y_LAST);
  assign head_sof  = queue_data[SOF_BIT];
  assign head_pix  = queue_data[PIX_W-1:0];

  // SOF must appear on the first window pixel and nowhere else.
  logic sof_misplaced;
  assign sof_misplaced = (first_px != head_sof);

  state_t state_reg;
  state_t state_next;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= SYNC_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SYNC_WAIT: begin
        // Only lock on at the frame boundary so the SOF word lands on the
        // first window pixel of the coming frame.
        if (frame_end && !queue_empty && head_sof) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (in_window && (queue_empty || sof_misplaced)) begin
          state_next = SYNC_WAIT;
        end
      end
      default: state_next = SYNC_WAIT;
    endcase
  end

  // Output logic: pop request, error pulses and the pixel for this position
  logic             pop;
  logic             underflow_set;
  logic             align_set;
  logic             frame_done;
  logic [PIX_W-1:0] pixel_next;

  always_comb begin
    pop           = 1'b0;
    underflow_set = 1'b0;
    align_set     = 1'b0;
    frame_done    = 1'b0;
    pixel_next    = in_window ? UNDERFLOW_COLOR : BORDER_COLOR;
    case (state_reg)
      SYNC_WAIT: begin
        // Discard stale words; an SOF head is held for the next frame.
        pop = !queue_empty && !head_sof;
      end
      STREAM: begin
        if (in_window) begin
          if (queue_empty) begin
            underflow_set = 1'b1;
          end else if (sof_misplaced) begin
            align_set = 1'b1;
          end else begin
            pop        = 1'b1;
            pixel_next = head_pix;
            frame_done = last_px;
          end
        end
      end
      default: ;
    endcase
  end

  // Gate with reset so nothing is drained while the block is held in reset.
  assign queue_rd_en = pop && reset_n;

  logic             de_reg;
  logic             hsync_reg;
  logic             vsync_reg;
  logic [PIX_W-1:0] rgb_reg;
  logic             underflow_reg;
  logic             align_reg;
  logic [15:0]      frame_count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      de_reg          <= 1'b0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      rgb_reg         <= '0;
      underflow_reg   <= 1'b0;
      align_reg       <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      de_reg          <= active;
      hsync_reg       <= hsync_raw;
      vsync_reg       <= vsync_raw;
      rgb_reg         <= active ? pixel_next : '0;
      // A new error in the same cycle as err_clear keeps the flag set.
      underflow_reg   <= underflow_set || (underflow_reg && !err_clear);
      align_reg       <= align_set || (align_reg && !err_clear);
      frame_count_reg <= frame_count_reg + {15'b0, frame_done};
    end
  end

  assign lcd_de        = de_reg;
  assign lcd_hsync     = hsync_reg;
  assign lcd_vsync     = vsync_reg;
  assign lcd_r         = rgb_reg[R_MSB:R_LSB];
  assign lcd_g         = rgb_reg[G_MSB:G_LSB];
  assign lcd_b         = rgb_reg[B_MSB:B_LSB];
  assign underflow_err = underflow_reg;
  assign align_err     = align_reg;
  assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_lcd_frame_scanner.sv
module tb_lcd_frame_scanner;

  // Small panel: 14 clocks per line, 7 lines per frame.
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int IW = 4, IH = 2, XO = 2, YO = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [16:0] queue_data = 17'h0;
  logic        queue_empty = 1'b1;
  logic        queue_rd_en;
  logic        lcd_de, lcd_hsync, lcd_vsync;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;
  logic        err_clear = 1'b0;
  logic        underflow_err, align_err;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  lcd_frame_scanner #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .X_OFFSET(XO), .Y_OFFSET(YO),
    .BORDER_COLOR(16'h0000), .UNDERFLOW_COLOR(16'hF800)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .queue_data(queue_data), .queue_empty(queue_empty), .queue_rd_en(queue_rd_en),
    .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .err_clear(err_clear), .underflow_err(underflow_err), .align_err(align_err),
    .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // rq: the queue the DUT actually pops; mq: what the model expects to remain.
  logic [16:0] rq[$];
  logic [16:0] mq[$];

  // Reference model state
  int          n;          // raster position as a linear index within the frame
  bit          m_stream;
  bit          m_uf, m_al;
  logic [15:0] m_fc;
  logic        e_de, e_hs, e_vs;
  logic [15:0] e_rgb;
  bit          arm_clear, clear_hit;

  function automatic logic [15:0] rgb();
    return {lcd_r, lcd_g, lcd_b};
  endfunction

  task automatic refresh_queue();
    queue_empty = (rq.size() == 0);
    queue_data  = (rq.size() > 0) ? rq[0] : 17'h0;
  endtask

  task automatic push_word(input logic [16:0] w);
    rq.push_back(w);
    mq.push_back(w);
    refresh_queue();
  endtask

  // Frame of len words, SOF on word 0; seq gives data 1,2,3... else random.
  task automatic push_frame(input int len, input bit seq);
    for (int i = 0; i < len; i++) begin
      logic [15:0] d;
      d = seq ? 16'(i + 1) : 16'($urandom);
      push_word({(i == 0), d});
    end
  endtask

  task automatic model_reset_state();
    n = 0; m_stream = 0; m_uf = 0; m_al = 0; m_fc = 16'h0;
    e_de = 0; e_hs = 1; e_vs = 1; e_rgb = 16'h0;
  endtask

  // One pixel clock: compare the DUT with the model, then advance both.
  task automatic run_cycle();
    int h, v;
    bit act, inw, first, last, emp, sof, pop, suf, sal, done, rst_s, clr_s, rd_s, nstr, armed_now;
    logic [15:0] col;
    @(negedge clk);
    h = n % HT;
    v = n / HT;
    act   = (h < HA) && (v < VA);
    inw   = (h >= XO) && (h < XO + IW) && (v >= YO) && (v < YO + IH);
    first = (h == XO) && (v == YO);
    last  = (h == XO + IW - 1) && (v == YO + IH - 1);
    emp   = (mq.size() == 0);
    sof   = emp ? 1'b0 : mq[0][16];
    pop = 0; suf = 0; sal = 0; done = 0; nstr = m_stream;
    col = inw ? 16'hF800 : 16'h0000;
    if (!m_stream) begin
      pop = !emp && !sof;
      if (h == HT - 1 && v == VT - 1 && !emp && sof) nstr = 1;
    end else if (inw) begin
      if (emp) begin
        suf = 1; nstr = 0;
      end else if ((first && !sof) || (!first && sof)) begin
        sal = 1; nstr = 0;
      end else begin
        pop = 1; col = mq[0][15:0]; done = last;
      end
    end
    rst_s = !reset_n;
    if (rst_s) pop = 0;

    n_checks++;
    if (queue_rd_en !== pop) begin
      n_fail++; $display("FAIL rd_en @(%0d,%0d): got %b want %b", h, v, queue_rd_en, pop);
    end
    n_checks++;
    if (lcd_de !== e_de) begin
      n_fail++; $display("FAIL de @(%0d,%0d): got %b want %b", h, v, lcd_de, e_de);
    end
    n_checks++;
    if (lcd_hsync !== e_hs) begin
      n_fail++; $display("FAIL hsync @(%0d,%0d): got %b want %b", h, v, lcd_hsync, e_hs);
    end
    n_checks++;
    if (lcd_vsync !== e_vs) begin
      n_fail++; $display("FAIL vsync @(%0d,%0d): got %b want %b", h, v, lcd_vsync, e_vs);
    end
    n_checks++;
    if (rgb() !== e_rgb) begin
      n_fail++; $display("FAIL rgb @(%0d,%0d): got %h want %h", h, v, rgb(), e_rgb);
    end
    n_checks++;
    if (underflow_err !== m_uf) begin
      n_fail++; $display("FAIL underflow_err @(%0d,%0d): got %b want %b", h, v, underflow_err, m_uf);
    end
    n_checks++;
    if (align_err !== m_al) begin
      n_fail++; $display("FAIL align_err @(%0d,%0d): got %b want %b", h, v, align_err, m_al);
    end
    n_checks++;
    if (frame_count !== m_fc) begin
      n_fail++; $display("FAIL frame_count @(%0d,%0d): got %0d want %0d", h, v, frame_count, m_fc);
    end

    armed_now = 0;
    if (arm_clear && suf && !rst_s) begin
      err_clear = 1'b1; clear_hit = 1; arm_clear = 0; armed_now = 1;
    end
    clr_s = err_clear;
    rd_s  = queue_rd_en;

    @(posedge clk);
    #1;
    if (rd_s && rq.size() > 0) void'(rq.pop_front());
    if (pop) void'(mq.pop_front());
    if (rst_s) begin
      model_reset_state();
    end else begin
      e_de  = act;
      e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
      e_rgb = act ? col : 16'h0000;
      m_uf  = suf || (m_uf && !clr_s);
      m_al  = sal || (m_al && !clr_s);
      m_fc  = m_fc + 16'(done);
      m_stream = nstr;
      n = (n + 1) % FRAME;
    end
    if (armed_now) err_clear = 1'b0;
    refresh_queue();
  endtask

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) run_cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run_cycles(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset_state();
    n_checks++;
    if (lcd_de !== 1'b0 || lcd_hsync !== 1'b1 || lcd_vsync !== 1'b1 || rgb() !== 16'h0) begin
      n_fail++; $display("FAIL reset_lcd: got de=%b hs=%b vs=%b rgb=%h want 0 1 1 0000",
                         lcd_de, lcd_hsync, lcd_vsync, rgb());
    end
    n_checks++;
    if (underflow_err !== 1'b0 || align_err !== 1'b0 || frame_count !== 16'h0 || queue_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got uf=%b al=%b fc=%0d rd=%b want 0 0 0 0",
                         underflow_err, align_err, frame_count, queue_rd_en);
    end
    run_cycles(2);
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_discard_stream();
    do_reset();
    for (int i = 0; i < 3; i++) push_word({1'b0, 16'($urandom)});
    push_frame(8, 1);
    run_cycles(4);
    n_checks++;
    if (rq.size() != 8) begin
      n_fail++; $display("FAIL discard: queue depth %0d want 8", rq.size());
    end
    run_cycles(2 * FRAME);
    n_checks++;
    if (frame_count !== 16'd1) begin
      n_fail++; $display("FAIL stream_count: frame_count %0d want 1", frame_count);
    end
    $display("test_discard_stream done");
  endtask

  task automatic test_underflow();
    do_reset();
    push_frame(8, 1);
    push_frame(5, 1);
    run_cycles(3 * FRAME);
    n_checks++;
    if (underflow_err !== 1'b1 || frame_count !== 16'd1) begin
      n_fail++; $display("FAIL underflow: got uf=%b fc=%0d want 1 1", underflow_err, frame_count);
    end
    push_frame(8, 1);
    run_cycles(2 * FRAME);
    n_checks++;
    if (frame_count !== 16'd2) begin
      n_fail++; $display("FAIL underflow_recover: frame_count %0d want 2", frame_count);
    end
    $display("test_underflow done");
  endtask

  task automatic test_align();
    do_reset();
    push_word({1'b1, 16'h0A01});
    push_word({1'b0, 16'h0A02});
    push_frame(8, 1);
    run_cycles(3 * FRAME);
    n_checks++;
    if (align_err !== 1'b1 || frame_count !== 16'd1 || rq.size() != 0) begin
      n_fail++; $display("FAIL align: got al=%b fc=%0d left=%0d want 1 1 0",
                         align_err, frame_count, rq.size());
    end
    $display("test_align done");
  endtask

  task automatic test_err_clear();
    do_reset();
    push_frame(5, 0);
    arm_clear = 1; clear_hit = 0;
    run_cycles(2 * FRAME);
    n_checks++;
    if (clear_hit !== 1'b1 || underflow_err !== 1'b1) begin
      n_fail++; $display("FAIL clear_vs_set: got hit=%b uf=%b want 1 1", clear_hit, underflow_err);
    end
    arm_clear = 0;
    err_clear = 1'b1;
    run_cycle();
    err_clear = 1'b0;
    n_checks++;
    if (underflow_err !== 1'b0) begin
      n_fail++; $display("FAIL clean_clear: got uf=%b want 0", underflow_err);
    end
    $display("test_err_clear done");
  endtask

  task automatic test_timing_empty();
    int hs_low, vs_low, de_hi, rd_hi;
    do_reset();
    hs_low = 0; vs_low = 0; de_hi = 0; rd_hi = 0;
    for (int i = 0; i < FRAME; i++) begin
      run_cycle();
      if (lcd_hsync === 1'b0) hs_low++;
      if (lcd_vsync === 1'b0) vs_low++;
      if (lcd_de === 1'b1) de_hi++;
      if (queue_rd_en === 1'b1) rd_hi++;
    end
    n_checks++;
    if (hs_low != 2 * VT || vs_low != HT) begin
      n_fail++; $display("FAIL sync_widths: got hs_low=%0d vs_low=%0d want %0d %0d",
                         hs_low, vs_low, 2 * VT, HT);
    end
    n_checks++;
    if (de_hi != HA * VA || rd_hi != 0) begin
      n_fail++; $display("FAIL de_count: got de=%0d rd=%0d want %0d 0", de_hi, rd_hi, HA * VA);
    end
    $display("test_timing_empty done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_frame(8, 0);
    push_frame(8, 1);
    run_cycles(FRAME + 25);
    reset_n = 1'b0;
    run_cycle();
    n_checks++;
    if (lcd_de !== 1'b0 || lcd_hsync !== 1'b1 || lcd_vsync !== 1'b1 || rgb() !== 16'h0 ||
        frame_count !== 16'h0 || queue_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got de=%b hs=%b vs=%b rgb=%h fc=%0d rd=%b want 0 1 1 0000 0 0",
                         lcd_de, lcd_hsync, lcd_vsync, rgb(), frame_count, queue_rd_en);
    end
    reset_n = 1'b1;
    run_cycles(3 * FRAME);
    n_checks++;
    if (frame_count !== 16'd1 || rq.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_resync: got fc=%0d left=%0d want 1 0", frame_count, rq.size());
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 12; it++) begin
      int garbage, len;
      garbage = $urandom_range(0, 3);
      len     = $urandom_range(3, 9);
      for (int i = 0; i < garbage; i++) push_word({1'b0, 16'($urandom)});
      for (int i = 0; i < len; i++) begin
        bit sof;
        sof = (i == 0) || ($urandom_range(0, 15) == 0);
        push_word({sof, 16'($urandom)});
      end
      for (int c = 0; c < 2 * FRAME; c++) begin
        err_clear = ($urandom_range(0, 31) == 0);
        run_cycle();
      end
      err_clear = 1'b0;
    end
    $display("test_random done: frame_count=%0d", frame_count);
  endtask

  initial begin
    arm_clear = 0; clear_hit = 0;
    test_reset();
    test_discard_stream();
    test_underflow();
    test_align();
    test_err_clear();
    test_timing_empty();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
